imem_dmem_arbiter: RTL

- Shares one single-port synchronous word memory between the pipeline's instruction-fetch port and its load/store port.
- Arbitrates requests, sequences the memory command/latency window and routes read data back to the winner.
- Data port has priority; a starvation counter guarantees fetch progress.
- Sits between the RV32I pipeline stages and the unified `mem` array.

---
 rtl/rv32i_mem_pkg.sv | 15 +
 rtl/arb_prio_sel.sv | 32 +++
 rtl/imem_dmem_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/rv32i_mem_pkg.sv
// rv32i_mem_pkg: shared encodings and widths for the unified instruction/data memory arbiter
package rv32i_mem_pkg;
  localparam int DW = 32;
  localparam int BW = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_t;
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;
endpackage

// File: rtl/arb_prio_sel.sv
// arb_prio_sel: data-priority winner select with a saturating fetch starvation counter
module arb_prio_sel
  import rv32i_mem_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   if_req,
  input  logic   d_req,
  input  logic   decide,
  output logic   win_valid,
  output owner_t win,
  output logic   conflict,
  output logic   forced
);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  logic [3:0] starve_cnt;
  // data wins a conflict unless fetch has already lost STARVE_MAX times in a row
  always_comb begin
    conflict  = if_req && d_req;
    forced    = conflict && (starve_cnt == SMAX);
    win_valid = if_req || d_req;
    win       = (d_req && !forced) ? OWN_D : OWN_IF;
  end
  // count consecutive fetch losses; any fetch grant clears the count
  always_ff @(posedge clk or posedge rst)
    if (rst) starve_cnt <= '0;
    else if (decide && win_valid)
      starve_cnt <= (win == OWN_IF) ? '0 :
                    (conflict && starve_cnt != SMAX) ? starve_cnt + 1'b1 : starve_cnt;
endmodule

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one single-port word memory between fetch and load/store ports.
// Define ARB_PERF_CNT_EN to add saturating conflict and forced-fetch counters.
module imem_dmem_arbiter
  import rv32i_mem_pkg::*;
#(
  parameter int AW         = 10,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [BW-1:0] d_be,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic [BW-1:0] m_be,
  input  logic [DW-1:0] m_rdata,
`ifdef ARB_PERF_CNT_EN
  output logic [15:0]   perf_conflicts,
  output logic [15:0]   perf_forced,
`endif
  output logic          busy
);
  localparam logic [1:0] LAT_INIT = 2'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);
  arb_state_t state;
  owner_t     owner;
  owner_t     win;
  logic       win_valid;
  logic       conflict;
  logic       forced;
  logic       idle;
  logic [1:0] lat_cnt;
  assign idle     = (state == IDLE);
  assign busy     = !idle;
  assign if_rdata = if_rvalid ? m_rdata : '0;
  assign d_rdata  = d_rvalid ? m_rdata : '0;
  arb_prio_sel #(.STARVE_MAX(STARVE_MAX)) u_sel (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .d_req     (d_req),
    .decide    (idle),
    .win_valid (win_valid),
    .win       (win),
    .conflict  (conflict),
    .forced    (forced)
  );
  // command/latency sequencer: grant and memory strobe are one-cycle pulses, rvalid marks RESP
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      lat_cnt   <= '0;
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      m_en      <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_be      <= '0;
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      m_en      <= 1'b0;
      m_we      <= 1'b0;
      m_be      <= '0;
      case (state)
        IDLE:
          if (win_valid) begin
            state   <= CMD;
            owner   <= win;
            if_gnt  <= (win == OWN_IF);
            d_gnt   <= (win == OWN_D);
            m_en    <= 1'b1;
            m_we    <= (win == OWN_D) && d_we;
            m_addr  <= (win == OWN_D) ? d_addr : if_addr;
            m_wdata <= (win == OWN_D) ? d_wdata : '0;
            m_be    <= (win == OWN_D) ? d_be : '0;
          end
        CMD:
          if (m_we) state <= IDLE;
          else if (MEM_LAT == 1) begin
            state     <= RESP;
            if_rvalid <= (owner == OWN_IF);
            d_rvalid  <= (owner == OWN_D);
          end else begin
            state   <= WAIT;
            lat_cnt <= LAT_INIT;
          end
        WAIT:
          if (lat_cnt == 2'd0) begin
            state     <= RESP;
            if_rvalid <= (owner == OWN_IF);
            d_rvalid  <= (owner == OWN_D);
          end else lat_cnt <= lat_cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
`ifdef ARB_PERF_CNT_EN
  // saturating counts of contested decisions and of fetch grants forced by starvation
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_conflicts <= '0;
      perf_forced    <= '0;
    end else if (idle) begin
      if (conflict && perf_conflicts != 16'hFFFF) perf_conflicts <= perf_conflicts + 1'b1;
      if (forced && perf_forced != 16'hFFFF) perf_forced <= perf_forced + 1'b1;
    end
`else
  logic unused_perf;
  assign unused_perf = conflict ^ forced;
`endif
endmodule
